io_input_ctrl: RTL and testbench

- Sequences the CPU datapath's MMIO input/output transactions.
- On an input request from the datapath, it stalls the core until the user confirms (finish button or keyboard enter) and selects the data source: switches zero-extended, switches sign-extended, or the 32-bit keyboard value.
- Latches the value and returns it with a one-cycle valid.
- Owns the LED and tube output registers written by the datapath's store path.
- Sits between the datapath and the top-level I/O in the cpu clock domain.

---
 rtl/io_input_ctrl.sv | 121 ++++++++++++
 tb/tb_io_input_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_ctrl.sv
// MMIO input sequencer: stalls the core until the user confirms a read,
// then returns the selected source; also owns the LED/tube output registers.
module io_input_ctrl #(
  parameter int DATA_W = 32,
  parameter int SW_W   = 8,
  parameter int KB_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [1:0]        rd_src,
  input  logic [SW_W-1:0]   switch_in,
  input  logic [KB_W-1:0]   keyboard_in,
  input  logic              confirm,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              stall,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] led_reg,
  output logic [DATA_W-1:0] tube_reg,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_REL   = 2'b01,
    WAIT_PRESS = 2'b10,
    DONE       = 2'b11
  } state_e;

  localparam logic [1:0] SRC_ZX  = 2'b00;
  localparam logic [1:0] SRC_SX  = 2'b01;
  localparam logic [1:0] SRC_RSV = 2'b11;

  state_e            state_q;
  state_e            state_d;
  logic [1:0]        src_q;
  logic              capture;
  logic              err_done;
  logic [DATA_W-1:0] cap_data;

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    err_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_req) state_d = WAIT_REL;
      end
      WAIT_REL: begin
        // a reserved source skips the confirm handshake entirely
        if (!rd_req) begin
          state_d = IDLE;
        end else if (src_q == SRC_RSV) begin
          state_d  = DONE;
          err_done = 1'b1;
        end else if (!confirm) begin
          state_d = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (!rd_req) begin
          state_d = IDLE;
        end else if (confirm) begin
          state_d = DONE;
          capture = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cap_data = '0;
    unique case (src_q)
      SRC_ZX:  cap_data = {{(DATA_W-SW_W){1'b0}}, switch_in};
      SRC_SX:  cap_data = {{(DATA_W-SW_W){switch_in[SW_W-1]}}, switch_in};
      default: cap_data = DATA_W'(keyboard_in);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= 2'b00;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && rd_req) src_q <= rd_src;
      if (capture) begin
        rd_data <= cap_data;
      end else if (err_done) begin
        rd_data <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg  <= '0;
      tube_reg <= '0;
    end else if (wr_en) begin
      if (wr_sel) tube_reg <= wr_data;
      else        led_reg  <= wr_data;
    end
  end

  assign rd_valid  = (state_q == DONE);
  assign rd_err    = (state_q == DONE) && (src_q == SRC_RSV);
  assign stall     = rd_req && (state_q != DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Randomized scoreboard bench for io_input_ctrl: a driver issues reads and
// writes, a monitor pops expected read responses whenever rd_valid fires.
module tb_io_input_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [1:0]  rd_src;
  logic [7:0]  switch_in;
  logic [31:0] keyboard_in;
  logic        confirm;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic        stall;
  logic        wr_en;
  logic        wr_sel;
  logic [31:0] wr_data;
  logic [31:0] led_reg;
  logic [31:0] tube_reg;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  logic [32:0] sb[$];
  logic [31:0] led_m;
  logic [31:0] tube_m;
  logic [31:0] last_data;

  always #5 clk = ~clk;

  io_input_ctrl #(.DATA_W(32), .SW_W(8), .KB_W(32)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_src(rd_src),
    .switch_in(switch_in), .keyboard_in(keyboard_in),
    .confirm(confirm),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .stall(stall),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .led_reg(led_reg), .tube_reg(tube_reg),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] src,
                                        input logic [7:0] sw,
                                        input logic [31:0] kb);
    int s;
    s = int'($signed(sw));
    case (src)
      2'd0:    return 32'(sw);
      2'd1:    return s;
      2'd2:    return kb;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic conf_at(input int k, input int hold, input int low);
    if (k < hold) return 1'b1;
    if (k < hold + low) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rst && (rd_valid || rd_err)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%h/%b required=none",
                 rd_data, rd_err);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", rd_data, e[31:0]);
        chk("rd_err", 32'(rd_err), 32'(e[32]));
      end
    end
  end

  task automatic do_write(input logic sel, input logic [31:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    if (sel) tube_m = d; else led_m = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("led_reg", led_reg, led_m);
    chk("tube_reg", tube_reg, tube_m);
  endtask

  // Confirm pattern: high for hold cycles, low for low cycles, then high.
  task automatic do_read(input logic [1:0] src, input logic [7:0] sw,
                         input logic [31:0] kb, input int hold,
                         input int low, input bit keep_confirm,
                         input bit rnd_wr);
    int k1, k2, exp_cyc, cyc;
    bit got;
    if (src == 2'b11) begin
      exp_cyc = 2;
    end else begin
      k1 = (hold > 1) ? hold : 1;
      k2 = (k1 + 1 > hold + low) ? k1 + 1 : hold + low;
      exp_cyc = k2 + 1;
    end
    rd_src = src; switch_in = sw; keyboard_in = kb;
    rd_req = 1'b1;
    cyc = 0;
    confirm = conf_at(0, hold, low);
    sb.push_back({src == 2'b11, model(src, sw, kb)});
    got = 1'b0;
    while (!got && cyc < 300) begin
      #1;
      if (rd_valid) begin
        got = 1'b1;
        wr_en = 1'b0;
        chk("rd_latency", cyc, exp_cyc);
        chk("stall_done", 32'(stall), 32'd0);
      end else begin
        chk("stall_wait", 32'(stall), 32'd1);
        if (rnd_wr && $urandom_range(2) == 0) begin
          wr_en = 1'b1;
          wr_sel = 1'($urandom_range(1));
          wr_data = $urandom;
          if (wr_sel) tube_m = wr_data; else led_m = wr_data;
        end else begin
          wr_en = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
        confirm = conf_at(cyc, hold, low);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL read_timeout actual=none required=valid");
    end else begin
      last_data = model(src, sw, kb);
    end
    wr_en = 1'b0;
    rd_req = 1'b0;
    if (!keep_confirm) confirm = 1'b0;
    @(posedge clk); #1;
    chk("state_after", 32'(state_dbg), 32'd0);
    chk("led_after_read", led_reg, led_m);
    chk("tube_after_read", tube_reg, tube_m);
  endtask

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_src = 2'b00; switch_in = 8'h00;
    keyboard_in = 32'h0; confirm = 1'b0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_data = 32'h0;
    led_m = 32'h0; tube_m = 32'h0; last_data = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_led", led_reg, 32'h0);
    chk("rst_tube", tube_reg, 32'h0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_err", 32'(rd_err), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_write(1'b0, 32'h000000A5);
    do_write(1'b1, 32'h12345678);

    do_read(2'b00, 8'hF3, 32'h0, 0, 5, 1'b0, 1'b0);
    do_read(2'b01, 8'h80, 32'h0, 10, 2, 1'b0, 1'b0);
    do_read(2'b10, 8'h00, 32'h00001234, 0, 2, 1'b1, 1'b0);
    do_read(2'b10, 8'h00, 32'h00001234, 4, 2, 1'b0, 1'b0);
    do_read(2'b11, 8'h5A, 32'hDEADBEEF, 1, 1, 1'b0, 1'b0);

    // abort from WAIT_PRESS keeps the previous word
    rd_src = 2'b00; switch_in = 8'h3C; rd_req = 1'b1; confirm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_in_press", 32'(state_dbg), 32'd2);
    rd_req = 1'b0;
    @(posedge clk); #1;
    chk("abort_state", 32'(state_dbg), 32'd0);
    chk("abort_rd_data", rd_data, last_data);
    chk("abort_valid", 32'(rd_valid), 32'd0);

    // reset while waiting for release
    rd_src = 2'b10; keyboard_in = 32'hCAFEF00D; rd_req = 1'b1; confirm = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid_in_rel", 32'(state_dbg), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_state", 32'(state_dbg), 32'd0);
    chk("rstmid_rd_data", rd_data, 32'h0);
    chk("rstmid_valid", 32'(rd_valid), 32'd0);
    chk("rstmid_led", led_reg, 32'h0);
    led_m = 32'h0; tube_m = 32'h0; last_data = 32'h0;
    rst = 1'b0; rd_req = 1'b0; confirm = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      do_read(2'($urandom_range(3)), 8'($urandom), $urandom,
              int'($urandom_range(4)), int'($urandom_range(4, 1)),
              1'($urandom_range(1)), 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
